wash_cycle_ctrl: RTL and testbench
==================================

# wash_cycle_ctrl

Wash-program sequencer for the washing-machine controller: runs WASH → RINSE → SPIN countdowns on a 1 s tick derived from the system clock and drives the phase LEDs and remaining-time value. It consumes `power_led` and `pause_led` from the pause stage. It produces the `finish` level that clears that stage's pause latch when a program ends.

## Interface
- `CLK_HZ`, 100_000_000, clk cycles per 1 s tick (benches override to a small value)
- `WASH_S`, 12, wash phase length in seconds (≥1)
- `RINSE_S`, 9, rinse phase length in seconds (≥1)
- `SPIN_S`, 6, spin phase length in seconds (≥1); `WASH_S+RINSE_S+SPIN_S` ≤ 255
- `clk` in 1 system clock, rising edge
- `rst_n` in 1 asynchronous active-low reset
- `power_led` in 1 machine powered; asynchronous level
- `pause_led` in 1 pause active; asynchronous level from pause stage
- `start` in 1 start button/switch level; asynchronous
- `finish` out 1 high while program complete (DONE)
- `phase_led` out 3 {spin, rinse, wash}
- `phase_remain` out 8 seconds left in current phase
- `total_remain` out 8 seconds left in whole program

## Operation
- All three asynchronous inputs pass through 2-flop synchronizers. `start` additionally gets a rising-edge detector (sync output vs. its registered copy).
- States and encodings:
  - IDLE: `phase_led=000`
  - WASH: `001`
  - RINSE: `010`
  - SPIN: `100`
  - DONE: `111`
- Reset (`rst_n`=0):
  - State is IDLE.
  - `finish`=0, `phase_led`=000, `phase_remain`=0, `total_remain`=0.
  - Prescaler and synchronizers are cleared.
- Synchronized `power_led`=0, in any state:
  - Next edge forces IDLE with all outputs and the prescaler at their reset values.
  - This has highest priority.
- IDLE, on start edge with power=1 and pause=0:
  - Go to WASH.
  - `phase_remain`=WASH_S, `total_remain`=sum of the three phases, prescaler=0.
  - A start edge while paused is ignored.
- Run states (WASH/RINSE/SPIN):
  - Prescaler counts 0..CLK_HZ-1 and wraps; the wrap cycle is the tick.
  - While synchronized pause=1, the prescaler and both counters hold. The fractional second is kept, so resume continues mid-second.
  - On tick with `phase_remain`>1: decrement both counters.
  - On tick with `phase_remain`=1, advance and decrement `total_remain`:
    - WASH → RINSE, loading RINSE_S.
    - RINSE → SPIN, loading SPIN_S.
    - SPIN → DONE, with `phase_remain`=0 and `total_remain`=0.
  - Start edges are ignored.
- DONE:
  - `finish`=1 held.
  - A start edge with pause=0 restarts at WASH exactly as from IDLE; `finish` drops the same edge.
  - Power-off returns to IDLE.
- `total_remain` always equals the sum of the current `phase_remain` and all later phase lengths. It never underflows.

## Timing
- Input latency: an async input first sampled high at edge N is visible to the FSM at edge N+2. A start edge therefore registers WASH at edge N+2.
- Tick period is exactly CLK_HZ unpaused cycles. The first tick after start comes CLK_HZ cycles after entry to WASH.
- Unpaused program duration: (WASH_S+RINSE_S+SPIN_S)·CLK_HZ cycles from WASH entry to DONE entry.
- `finish` rises on the same edge that enters DONE. It is a registered output, glitch-free, and safe as the pause stage's async clear.
- Simultaneous events:
  - Power-off and tick on the same cycle: power-off wins.
  - Pause asserting on the tick cycle (already synchronized): the tick is suppressed and is taken after resume.
  - Start edge and power-off together: IDLE.
- `rst_n` mid-program aborts immediately (asynchronously) to IDLE. No resume state is retained.

## Test plan
- CLK_HZ=10, WASH_S=3, RINSE_S=2, SPIN_S=2. Power on, pulse start:
  - WASH at start+2 edges with `phase_remain`=3, `total_remain`=7.
  - RINSE after 30 cycles, SPIN after 50, DONE with `finish`=1 after 70.
  - `phase_led` steps 001/010/100/111.
- Pause for 25 cycles at prescaler=4 in WASH (`phase_remain`=2): counters and `phase_led` frozen throughout. After release the next tick arrives 6 cycles later (plus sync latency).
- Power-off mid-RINSE: IDLE within 3 edges, all outputs 0. A start pulse with power off leaves the block in IDLE.
- From DONE, pulse start: `finish` falls and WASH reloads 3/7. Start pulses during WASH/RINSE/SPIN change nothing.
- Assert `rst_n`=0 mid-SPIN: outputs clear immediately without a clock edge. After release the block idles until a start edge.
- Power-off asserted on the tick cycle that would enter DONE: IDLE with `finish` never asserting.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Wash-program sequencer: WASH -> RINSE -> SPIN countdowns on a prescaled 1 s tick,
// with synchronized power/pause/start inputs and a registered finish level.
module wash_cycle_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int WASH_S  = 12,
  parameter int RINSE_S = 9,
  parameter int SPIN_S  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_led,
  input  logic       pause_led,
  input  logic       start,
  output logic       finish,
  output logic [2:0] phase_led,
  output logic [7:0] phase_remain,
  output logic [7:0] total_remain
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  // State codes double as the phase LED pattern.
  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] WASH  = 3'b001;
  localparam logic [2:0] RINSE = 3'b010;
  localparam logic [2:0] SPIN  = 3'b100;
  localparam logic [2:0] DONE  = 3'b111;

  localparam logic [7:0] WASH_T  = 8'(WASH_S);
  localparam logic [7:0] RINSE_T = 8'(RINSE_S);
  localparam logic [7:0] SPIN_T  = 8'(SPIN_S);
  localparam logic [7:0] TOTAL_T = 8'(WASH_S + RINSE_S + SPIN_S);

  logic [1:0]    power_sync, pause_sync, start_sync;
  logic          start_q;
  logic          powered, paused, start_edge;
  logic [2:0]    state;
  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      power_sync <= '0;
      pause_sync <= '0;
      start_sync <= '0;
      start_q    <= 1'b0;
    end else begin
      power_sync <= {power_sync[0], power_led};
      pause_sync <= {pause_sync[0], pause_led};
      start_sync <= {start_sync[0], start};
      start_q    <= start_sync[1];
    end
  end

  assign powered    = power_sync[1];
  assign paused     = pause_sync[1];
  assign start_edge = start_sync[1] & ~start_q;
  assign phase_led  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      finish       <= 1'b0;
      phase_remain <= '0;
      total_remain <= '0;
      presc        <= '0;
    end else if (!powered) begin
      state        <= IDLE;
      finish       <= 1'b0;
      phase_remain <= '0;
      total_remain <= '0;
      presc        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge && !paused) begin
            state        <= WASH;
            finish       <= 1'b0;
            phase_remain <= WASH_T;
            total_remain <= TOTAL_T;
            presc        <= '0;
          end
        end
        WASH, RINSE, SPIN: begin
          // Pause freezes the prescaler too, so a resume continues mid-second.
          if (!paused) begin
            if (presc == PRESC_MAX) begin
              presc <= '0;
              if (phase_remain > 8'd1) begin
                phase_remain <= phase_remain - 8'd1;
                total_remain <= total_remain - 8'd1;
              end else begin
                total_remain <= total_remain - 8'd1;
                case (state)
                  WASH: begin
                    state        <= RINSE;
                    phase_remain <= RINSE_T;
                  end
                  RINSE: begin
                    state        <= SPIN;
                    phase_remain <= SPIN_T;
                  end
                  default: begin
                    state        <= DONE;
                    finish       <= 1'b1;
                    phase_remain <= '0;
                    total_remain <= '0;
                  end
                endcase
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          finish       <= 1'b0;
          phase_remain <= '0;
          total_remain <= '0;
          presc        <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Randomized bench for wash_cycle_ctrl against an elapsed-seconds reference model,
// plus directed latency, power-off-on-final-tick and async-reset scenarios.
module tb_wash_cycle_ctrl;
  localparam int HZ  = 10;
  localparam int WS  = 3;
  localparam int RS  = 2;
  localparam int SS  = 2;
  localparam int TOT = WS + RS + SS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power_led = 1'b0;
  logic       pause_led = 1'b0;
  logic       start = 1'b0;
  logic       finish;
  logic [2:0] phase_led;
  logic [7:0] phase_remain, total_remain;

  int n_tests = 0;
  int n_fail  = 0;

  wash_cycle_ctrl #(.CLK_HZ(HZ), .WASH_S(WS), .RINSE_S(RS), .SPIN_S(SS)) dut (
    .clk(clk), .rst_n(rst_n), .power_led(power_led), .pause_led(pause_led),
    .start(start), .finish(finish), .phase_led(phase_led),
    .phase_remain(phase_remain), .total_remain(total_remain)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Model: mode 0=idle 1=running 2=done; el = whole seconds elapsed, frac = cycles into second.
  int   mode, el, frac;
  logic pw_h1, pw_h2, pz_h1, pz_h2, st_h1, st_h2, st_h3;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mode = 0; el = 0; frac = 0;
    pw_h1 = 0; pw_h2 = 0; pz_h1 = 0; pz_h2 = 0; st_h1 = 0; st_h2 = 0; st_h3 = 0;
  endtask

  // Inputs reach the sequencer two edges after being sampled.
  task automatic model_edge();
    logic pw, pz, se;
    pw = pw_h2; pz = pz_h2; se = st_h2 && !st_h3;
    if (!pw) begin
      mode = 0; el = 0; frac = 0;
    end else if (mode != 1) begin
      if (se && !pz) begin mode = 1; el = 0; frac = 0; end
    end else if (!pz) begin
      if (frac == HZ - 1) begin
        frac = 0; el++;
        if (el == TOT) mode = 2;
      end else frac++;
    end
    st_h3 = st_h2; st_h2 = st_h1; st_h1 = start;
    pw_h2 = pw_h1; pw_h1 = power_led;
    pz_h2 = pz_h1; pz_h1 = pause_led;
  endtask

  task automatic compare();
    int e_led, e_pr, e_tr, e_fin;
    e_led = 0; e_pr = 0; e_tr = 0; e_fin = 0;
    if (mode == 2) begin
      e_fin = 1; e_led = 7;
    end else if (mode == 1) begin
      e_tr = TOT - el;
      if (el < WS)           begin e_led = 1; e_pr = WS - el; end
      else if (el < WS + RS) begin e_led = 2; e_pr = WS + RS - el; end
      else                   begin e_led = 4; e_pr = TOT - el; end
    end
    chk("phase_led", int'(phase_led), e_led);
    chk("phase_remain", int'(phase_remain), e_pr);
    chk("total_remain", int'(total_remain), e_tr);
    chk("finish", int'(finish), e_fin);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_led"}, int'(phase_led), 0);
    chk({tag, "_pr"}, int'(phase_remain), 0);
    chk({tag, "_tr"}, int'(total_remain), 0);
    chk({tag, "_fin"}, int'(finish), 0);
    model_reset();
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start_wait_wash(output int lat);
    start = 1'b1; step(); start = 1'b0;
    lat = 0;
    while (phase_led != 3'b001 && lat < 10) begin step(); lat++; end
  endtask

  initial begin
    int t, len, cyc;
    logic fin_seen;
    model_reset();
    #12;
    chk("rst_led", int'(phase_led), 0);
    chk("rst_pr", int'(phase_remain), 0);
    chk("rst_tr", int'(total_remain), 0);
    chk("rst_fin", int'(finish), 0);
    @(negedge clk);
    rst_n = 1'b1; power_led = 1'b1;
    repeat (3) step();

    // Full program: latency from start and duration to DONE.
    pulse_start_wait_wash(t);
    chk("start_to_wash", t, 2);
    chk("wash_load_pr", int'(phase_remain), WS);
    chk("wash_load_tr", int'(total_remain), TOT);
    t = 0;
    while (!finish && t < 200) begin step(); t++; end
    chk("wash_to_done", t, TOT * HZ);

    // Restart from DONE, then power-off landing exactly on the final tick.
    pulse_start_wait_wash(t);
    chk("restart_from_done", t, 2);
    repeat (TOT * HZ - 3) step();
    power_led = 1'b0;
    step();
    fin_seen = 1'b0;
    repeat (6) begin step(); if (finish) fin_seen = 1'b1; end
    chk("pwroff_final_tick_fin", int'(fin_seen), 0);
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    chk("start_unpowered_led", int'(phase_led), 0);

    // Async reset in the middle of SPIN.
    power_led = 1'b1;
    repeat (3) step();
    pulse_start_wait_wash(t);
    repeat ((WS + RS) * HZ + 5) step();
    chk("pre_reset_spin", int'(phase_led), 4);
    async_reset("spin_rst");
    repeat (5) step();

    // Randomized segments of power/pause levels with random start toggles.
    cyc = 0;
    while (cyc < 3000) begin
      len = $urandom_range(1, 60);
      power_led = ($urandom_range(0, 9) != 0);
      pause_led = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 11) == 0) start = ~start;
        if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
        step();
        cyc++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
